// File: rtl/gbf_fill_controller_if.sv
// gbf_fill_controller_if
// Bundles the request, stream and port-A write signals of one gbf fill controller.
//   finish, gbf1/2_need_data, fill_len     : fill requests from the gbf controller
//   in_valid, in_data, in_ready            : 512-bit valid/ready word stream
//   en/we/addr/w_data 1a/2a                : port-A write side of gbf buffers 1 and 2
//   buf1_ready, buf2_ready, data_avail     : completed-fill status
// master drives requests and stream words; slave is the fill controller.
interface gbf_fill_controller_if #(
  parameter int unsigned GBF_DATA_BITWIDTH = 512,
  parameter int unsigned GBF_ADDR_BITWIDTH = 5
);
  logic                         finish;
  logic                         gbf1_need_data;
  logic                         gbf2_need_data;
  logic [GBF_ADDR_BITWIDTH:0]   fill_len;
  logic                         in_valid;
  logic [GBF_DATA_BITWIDTH-1:0] in_data;
  logic                         in_ready;
  logic                         en1a;
  logic                         we1a;
  logic                         en2a;
  logic                         we2a;
  logic [GBF_ADDR_BITWIDTH-1:0] addr1a;
  logic [GBF_ADDR_BITWIDTH-1:0] addr2a;
  logic [GBF_DATA_BITWIDTH-1:0] w_data1a;
  logic [GBF_DATA_BITWIDTH-1:0] w_data2a;
  logic                         buf1_ready;
  logic                         buf2_ready;
  logic                         data_avail;

  modport master (
    output finish, gbf1_need_data, gbf2_need_data, fill_len, in_valid, in_data,
    input  in_ready, en1a, we1a, en2a, we2a, addr1a, addr2a, w_data1a, w_data2a,
    input  buf1_ready, buf2_ready, data_avail
  );

  modport slave (
    input  finish, gbf1_need_data, gbf2_need_data, fill_len, in_valid, in_data,
    output in_ready, en1a, we1a, en2a, we2a, addr1a, addr2a, w_data1a, w_data2a,
    output buf1_ready, buf2_ready, data_avail
  );
endinterface

// File: rtl/gbf_fill_controller.sv
// gbf_fill_controller
// Loads one gbf ping-pong buffer pair from a valid/ready word stream. A rising edge on a
// need input requests a refill of that buffer; fills are served one at a time, round-robin
// when both are pending. Each accepted word is written on port A of the selected buffer
// one cycle later; the buffer is reported ready once its last word is committed.
// Ports:
//   clk_i    : clock, rising edge
//   reset_i  : asynchronous active-high reset
//   gbf_io   : slave side of gbf_fill_controller_if (requests, stream, port A, status)
module gbf_fill_controller #(
  parameter int unsigned GBF_DATA_BITWIDTH = 512,
  parameter int unsigned GBF_ADDR_BITWIDTH = 5,
  parameter int unsigned GBF_DEPTH         = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  gbf_fill_controller_if.slave  gbf_io
);
  localparam int unsigned AW = GBF_ADDR_BITWIDTH;
  localparam int unsigned DW = GBF_DATA_BITWIDTH;
  localparam logic [AW:0]   DepthLen = (AW+1)'(GBF_DEPTH);
  localparam logic [AW:0]   LenOne   = (AW+1)'(1);
  localparam logic [AW-1:0] CntOne   = AW'(1);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  // Bit 0 of the 2-bit vectors is buffer 1, bit 1 is buffer 2; sel/last use the same coding.
  state_e        state_q, state_d;
  logic [1:0]    need_q, need_d;
  logic [1:0]    pending_q, pending_d;
  logic [1:0]    full_q, full_d;
  logic          last_q, last_d;
  logic          sel_q, sel_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          fin_seen_q, fin_seen_d;
  // The last write is committed one cycle after its handshake; full is set then.
  logic          commit_q, commit_d;
  logic          commit_sel_q, commit_sel_d;
  logic          in_ready_q, in_ready_d;
  logic [1:0]    en_q, en_d;
  logic [AW-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic [DW-1:0] data1_q, data1_d, data2_q, data2_d;
  logic          data_avail_q, data_avail_d;

  logic [1:0] need;
  logic [1:0] rise;
  logic       hs;
  logic       last_hs;

  assign need    = {gbf_io.gbf2_need_data, gbf_io.gbf1_need_data};
  assign rise    = need & ~need_q;
  assign hs      = in_ready_q & gbf_io.in_valid;
  assign last_hs = hs & ({1'b0, cnt_q} == (len_q - LenOne));

  always_comb begin
    state_d      = state_q;
    need_d       = need;
    pending_d    = pending_q;
    full_d       = full_q;
    last_d       = last_q;
    sel_d        = sel_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    fin_seen_d   = fin_seen_q;
    commit_d     = 1'b0;
    commit_sel_d = commit_sel_q;
    in_ready_d   = in_ready_q;
    en_d         = 2'b00;
    addr1_d      = addr1_q;
    addr2_d      = addr2_q;
    data1_d      = data1_q;
    data2_d      = data2_q;

    if (commit_q) full_d[commit_sel_q] = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (gbf_io.finish) begin
          state_d = StDone;
        end else if (pending_q != 2'b00) begin
          sel_d      = (pending_q == 2'b11) ? ~last_q : pending_q[1];
          len_d      = (gbf_io.fill_len == '0 || gbf_io.fill_len > DepthLen) ? DepthLen
                                                                             : gbf_io.fill_len;
          cnt_d      = '0;
          fin_seen_d = 1'b0;
          in_ready_d = 1'b1;
          state_d    = StFill;
        end
      end
      StFill: begin
        if (gbf_io.finish) fin_seen_d = 1'b1;
        if (hs) begin
          en_d[sel_q] = 1'b1;
          if (sel_q) begin
            addr2_d = cnt_q;
            data2_d = gbf_io.in_data;
          end else begin
            addr1_d = cnt_q;
            data1_d = gbf_io.in_data;
          end
          cnt_d = cnt_q + CntOne;
          if (last_hs) begin
            pending_d[sel_q] = 1'b0;
            last_d           = sel_q;
            commit_d         = 1'b1;
            commit_sel_d     = sel_q;
            in_ready_d       = 1'b0;
            state_d          = (fin_seen_q | gbf_io.finish) ? StDone : StIdle;
          end
        end
      end
      StDone: begin
        in_ready_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Applied last so a new request wins over the clear/commit of the same cycle.
    for (int i = 0; i < 2; i++) begin
      if (rise[i]) begin
        pending_d[i] = 1'b1;
        full_d[i]    = 1'b0;
      end
    end

    data_avail_d = |full_d;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      need_q       <= 2'b00;
      pending_q    <= 2'b00;
      full_q       <= 2'b00;
      last_q       <= 1'b1;  // buffer 2 served last, so buffer 1 wins the first tie
      sel_q        <= 1'b0;
      len_q        <= '0;
      cnt_q        <= '0;
      fin_seen_q   <= 1'b0;
      commit_q     <= 1'b0;
      commit_sel_q <= 1'b0;
      in_ready_q   <= 1'b0;
      en_q         <= 2'b00;
      addr1_q      <= '0;
      addr2_q      <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
      data_avail_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      need_q       <= need_d;
      pending_q    <= pending_d;
      full_q       <= full_d;
      last_q       <= last_d;
      sel_q        <= sel_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      fin_seen_q   <= fin_seen_d;
      commit_q     <= commit_d;
      commit_sel_q <= commit_sel_d;
      in_ready_q   <= in_ready_d;
      en_q         <= en_d;
      addr1_q      <= addr1_d;
      addr2_q      <= addr2_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      data_avail_q <= data_avail_d;
    end
  end

  assign gbf_io.in_ready   = in_ready_q;
  assign gbf_io.en1a       = en_q[0];
  assign gbf_io.we1a       = en_q[0];
  assign gbf_io.en2a       = en_q[1];
  assign gbf_io.we2a       = en_q[1];
  assign gbf_io.addr1a     = addr1_q;
  assign gbf_io.addr2a     = addr2_q;
  assign gbf_io.w_data1a   = data1_q;
  assign gbf_io.w_data2a   = data2_q;
  assign gbf_io.buf1_ready = full_q[0];
  assign gbf_io.buf2_ready = full_q[1];
  assign gbf_io.data_avail = data_avail_q;

endmodule
